// File: rtl/reg_wb_queue_pkg.sv
// Shared widths, depth default and entry type for the register writeback queue.
package reg_wb_queue_pkg;

    localparam int   REG_ADDR_BUS = 5;
    localparam int   REG_BUS      = 32;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam int   WBQ_DEPTH    = 4;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } wb_src_e;

    typedef struct packed {
        wb_src_e                 src;
        logic [REG_ADDR_BUS-1:0] wa;
        logic [REG_BUS-1:0]      wd;
    } wb_entry_t;

    // One-hot mask selecting register r in a per-register bit vector.
    function automatic logic [REG_BUS-1:0] reg_onehot(input logic [REG_ADDR_BUS-1:0] r);
        return REG_BUS'(1) << r;
    endfunction

endpackage

// File: rtl/reg_wb_queue_if.sv
// Writeback requests, allocation, hazard query and register-file write port.
interface reg_wb_queue_if;
    import reg_wb_queue_pkg::*;

    logic                    a_valid;
    logic [REG_ADDR_BUS-1:0] a_wa;
    logic [REG_BUS-1:0]      a_wd;
    logic                    a_ready;
    logic                    b_valid;
    logic [REG_ADDR_BUS-1:0] b_wa;
    logic [REG_BUS-1:0]      b_wd;
    logic                    b_ready;
    logic                    alloc_valid;
    logic [REG_ADDR_BUS-1:0] alloc_wa;
    logic                    re1;
    logic [REG_ADDR_BUS-1:0] ra1;
    logic                    re2;
    logic [REG_ADDR_BUS-1:0] ra2;
    logic                    we;
    logic [REG_ADDR_BUS-1:0] wa;
    logic [REG_BUS-1:0]      wd;
    logic [REG_BUS-1:0]      pending;
    logic                    stall;

    modport master (
        output a_valid, a_wa, a_wd, b_valid, b_wa, b_wd,
               alloc_valid, alloc_wa, re1, ra1, re2, ra2,
        input  a_ready, b_ready, we, wa, wd, pending, stall
    );

    modport slave (
        input  a_valid, a_wa, a_wd, b_valid, b_wa, b_wd,
               alloc_valid, alloc_wa, re1, ra1, re2, ra2,
        output a_ready, b_ready, we, wa, wd, pending, stall
    );

endinterface

// File: rtl/reg_wb_queue_wbq_fifo.sv
// In-order entry FIFO: up to two pushes (push0 ahead of push1) and one pop per cycle.
module wbq_fifo
    import reg_wb_queue_pkg::*;
#(
    parameter  int DEPTH = WBQ_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push0_i,
    input  wb_entry_t             push0_data_i,
    input  logic                  push1_i,
    input  wb_entry_t             push1_data_i,
    input  logic                  pop_i,
    output logic                  empty_o,
    output wb_entry_t             head_o,
    output logic [AW:0]           count_o,
    output logic [DEPTH-1:0]      tail_valid_o,
    output wb_entry_t [DEPTH-1:0] entries_o
);

    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [AW:0]           count_q, count_d;
    wb_entry_t [DEPTH-1:0] mem_q;
    logic                  wr_first_s, wr_second_s, do_pop_s;
    wb_entry_t             first_data_s;
    logic [AW-1:0]         off_s [DEPTH];

    // A lone push1 is compacted into the first free slot.
    always_comb begin
        wr_first_s  = push0_i | push1_i;
        wr_second_s = push0_i & push1_i;
        do_pop_s    = pop_i & (count_q != (AW+1)'(0));
        if (push0_i) begin
            first_data_s = push0_data_i;
        end else begin
            first_data_s = push1_data_i;
        end
        wptr_d  = wptr_q + AW'(wr_first_s) + AW'(wr_second_s);
        rptr_d  = rptr_q + AW'(do_pop_s);
        count_d = count_q + (AW+1)'(wr_first_s) + (AW+1)'(wr_second_s) - (AW+1)'(do_pop_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= AW'(0);
            rptr_q  <= AW'(0);
            count_q <= (AW+1)'(0);
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset because occupancy gates every use.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (wr_first_s) begin
                mem_q[wptr_q] <= first_data_s;
            end
            if (wr_second_s) begin
                mem_q[wptr_q + AW'(1)] <= push1_data_i;
            end
        end
    end

    // Valid entries other than the head, by storage slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            off_s[i]        = AW'(i) - rptr_q;
            tail_valid_o[i] = (off_s[i] != AW'(0)) && ({1'b0, off_s[i]} < count_q);
        end
    end

    assign empty_o   = (count_q == (AW+1)'(0));
    assign head_o    = mem_q[rptr_q];
    assign count_o   = count_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/reg_wb_queue.sv
// Register writeback queue: merges pipeline and long-latency writebacks onto one
// register-file write port and tracks outstanding long-latency destinations.
module reg_wb_queue
    import reg_wb_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH
) (
    input  logic          cpu_clk_50M,
    input  logic          cpu_rst,
    reg_wb_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 2;

    logic                  fifo_empty_s;
    wb_entry_t             head_s;
    logic [AW:0]           count_s;
    logic [DEPTH-1:0]      tail_valid_s;
    wb_entry_t [DEPTH-1:0] entries_s;
    wb_entry_t             a_entry_s, b_entry_s;
    logic                  pop_s, push_a_s, push_b_s;
    logic [FW-1:0]         free_s;
    logic                  a_ready_s, b_ready_s;
    logic [REG_BUS-1:0]    pending_q, pending_d, set_s, clr_s;
    logic                  hit1_s, hit2_s, stall_s;

    // Free slots count the head leaving this cycle; ready never looks at its own valid.
    always_comb begin
        pop_s     = ~fifo_empty_s;
        free_s    = FW'(DEPTH) - FW'(count_s) + FW'(pop_s);
        a_ready_s = (free_s >= FW'(1));
        if (bus.a_valid) begin
            b_ready_s = (free_s >= FW'(2));
        end else begin
            b_ready_s = (free_s >= FW'(1));
        end
        push_a_s  = bus.a_valid && a_ready_s && (bus.a_wa != REG_ADDR_BUS'(0));
        push_b_s  = bus.b_valid && b_ready_s && (bus.b_wa != REG_ADDR_BUS'(0));
        a_entry_s = '{src: SRC_A, wa: bus.a_wa, wd: bus.a_wd};
        b_entry_s = '{src: SRC_B, wa: bus.b_wa, wd: bus.b_wd};
    end

    wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (cpu_clk_50M),
        .rst_i        (cpu_rst),
        .push0_i      (push_a_s),
        .push0_data_i (a_entry_s),
        .push1_i      (push_b_s),
        .push1_data_i (b_entry_s),
        .pop_i        (pop_s),
        .empty_o      (fifo_empty_s),
        .head_o       (head_s),
        .count_o      (count_s),
        .tail_valid_o (tail_valid_s),
        .entries_o    (entries_s)
    );

    // Allocation wins over a same-cycle retirement of the same register.
    always_comb begin
        if (bus.alloc_valid && (bus.alloc_wa != REG_ADDR_BUS'(0))) begin
            set_s = reg_onehot(bus.alloc_wa);
        end else begin
            set_s = REG_BUS'(0);
        end
        if (pop_s && (head_s.src == SRC_B)) begin
            clr_s = reg_onehot(head_s.wa);
        end else begin
            clr_s = REG_BUS'(0);
        end
        pending_d    = (pending_q & ~clr_s) | set_s;
        pending_d[0] = 1'b0;
    end

    // Outstanding long-latency destination bits.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            pending_q <= REG_BUS'(0);
        end else begin
            pending_q <= pending_d;
        end
    end

    // The head is being written this cycle and the register file bypasses it.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1_s = hit1_s | (tail_valid_s[i] && (entries_s[i].wa == bus.ra1));
            hit2_s = hit2_s | (tail_valid_s[i] && (entries_s[i].wa == bus.ra2));
        end
        stall_s = (bus.re1 && (bus.ra1 != REG_ADDR_BUS'(0)) && (pending_q[bus.ra1] || hit1_s)) ||
                  (bus.re2 && (bus.ra2 != REG_ADDR_BUS'(0)) && (pending_q[bus.ra2] || hit2_s));
    end

    // Write port shows the head entry and is zeroed while empty.
    always_comb begin
        if (fifo_empty_s) begin
            bus.we = ~WRITE_ENABLE;
            bus.wa = REG_ADDR_BUS'(0);
            bus.wd = REG_BUS'(0);
        end else begin
            bus.we = WRITE_ENABLE;
            bus.wa = head_s.wa;
            bus.wd = head_s.wd;
        end
    end

    assign bus.a_ready = a_ready_s;
    assign bus.b_ready = b_ready_s;
    assign bus.pending = pending_q;
    assign bus.stall   = stall_s;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Randomized and directed bench for reg_wb_queue against a queue-based reference model.
module tb_reg_wb_queue;
    import reg_wb_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_wb_queue_if bus();

    reg_wb_queue #(.DEPTH(DEPTH)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .bus         (bus)
    );

    typedef struct {
        bit        src;
        bit [4:0]  wa;
        bit [31:0] wd;
    } ent_t;

    ent_t      model_q[$];
    ent_t      exp_q[$];
    bit [31:0] pend_m = 32'd0;
    int        n_pass = 0;
    int        n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic bit hz(input bit e, input bit [4:0] a);
        if (!e || a == 5'd0) return 1'b0;
        if (pend_m[a]) return 1'b1;
        for (int i = 1; i < model_q.size(); i++)
            if (model_q[i].wa == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_wa = 5'd0; bus.a_wd = 32'd0;
        bus.b_valid = 1'b0; bus.b_wa = 5'd0; bus.b_wd = 32'd0;
        bus.alloc_valid = 1'b0; bus.alloc_wa = 5'd0;
        bus.re1 = 1'b0; bus.ra1 = 5'd0; bus.re2 = 1'b0; bus.ra2 = 5'd0;
    endtask

    // One cycle: drive, check combinational outputs against the model, then advance the model.
    task automatic req(input bit av, input bit [4:0] awa, input bit [31:0] awd,
                       input bit bv, input bit [4:0] bwa, input bit [31:0] bwd,
                       input bit alv, input bit [4:0] alwa,
                       input bit r1e, input bit [4:0] r1a, input bit r2e, input bit [4:0] r2a);
        int        free;
        bit        ar, br;
        ent_t      e;
        bit [31:0] clr, set;
        @(negedge clk);
        rst = 1'b0;
        bus.a_valid = av; bus.a_wa = awa; bus.a_wd = awd;
        bus.b_valid = bv; bus.b_wa = bwa; bus.b_wd = bwd;
        bus.alloc_valid = alv; bus.alloc_wa = alwa;
        bus.re1 = r1e; bus.ra1 = r1a; bus.re2 = r2e; bus.ra2 = r2a;
        #1;
        free = DEPTH - model_q.size() + ((model_q.size() > 0) ? 1 : 0);
        ar = (free >= 1);
        br = av ? (free >= 2) : (free >= 1);
        chk("a_ready", bus.a_ready, ar);
        chk("b_ready", bus.b_ready, br);
        chk("we", bus.we, model_q.size() != 0);
        chk("wa", bus.wa, (model_q.size() != 0) ? model_q[0].wa : 5'd0);
        chk("wd", bus.wd, (model_q.size() != 0) ? model_q[0].wd : 32'd0);
        chk("pending", bus.pending, pend_m);
        chk("stall", bus.stall, hz(r1e, r1a) || hz(r2e, r2a));
        @(posedge clk);
        clr = 32'd0;
        set = 32'd0;
        if (model_q.size() > 0) begin
            e = model_q.pop_front();
            if (e.src) clr[e.wa] = 1'b1;
        end
        if (alv && alwa != 5'd0) set[alwa] = 1'b1;
        pend_m = (pend_m & ~clr) | set;
        if (av && ar && awa != 5'd0) begin
            model_q.push_back('{1'b0, awa, awd});
            exp_q.push_back('{1'b0, awa, awd});
        end
        if (bv && br && bwa != 5'd0) begin
            model_q.push_back('{1'b1, bwa, bwd});
            exp_q.push_back('{1'b1, bwa, bwd});
        end
    endtask

    task automatic idle();
        req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.a_valid = 1'b1; bus.a_wa = 5'd11; bus.a_wd = $urandom;
        bus.b_valid = 1'b1; bus.b_wa = 5'd12; bus.b_wd = $urandom;
        bus.alloc_valid = 1'b1; bus.alloc_wa = 5'd13;
        @(posedge clk);
        model_q.delete();
        exp_q.delete();
        pend_m = 32'd0;
    endtask

    // Monitor: every presented write must be the next expected one, in order.
    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_we", bus.we, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_wa", bus.wa, e.wa);
                    chk("wr_wd", bus.wd, e.wd);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        do_reset();
        idle();
        // Single pipeline write, then two writes in one cycle, then a non-head hazard.
        req(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        idle(); idle();
        req(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        idle(); idle(); idle();
        req(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h67, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6);
        req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6);
        idle();
        // Saturate both request ports.
        for (int i = 0; i < 8; i++)
            req(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom,
                1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 6; i++) idle();
        // Pending lifecycle for r7, including alloc coinciding with retirement.
        req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        req(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0);
        req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
        req(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0);
        req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0);
        req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0);
        // Writes to r0 are swallowed.
        req(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
        idle(); idle();
        // Reset with three queued entries and r9 pending.
        req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
        req(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        req(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0);
        do_reset();
        for (int i = 0; i < 4; i++) idle();
        // Random traffic over a small register range to force collisions.
        for (int i = 0; i < 400; i++)
            req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom,
                ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 9)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)));
        for (int i = 0; i < 3 * DEPTH && model_q.size() != 0; i++) idle();
        idle(); idle();
        chk("drain_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of buffered write entries (power of 2, >=2).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 cpu_clk_50M  in  1  sole clock, all state updates on rising edge.
REQ-004 cpu_rst  in  1  synchronous active-high reset.
REQ-005 a_valid/a_wa/a_wd  in  1/5/32  pipeline writeback request, address, data; a_ready out 1.
REQ-006 b_valid/b_wa/b_wd  in  1/5/32  long-latency unit (load/div) writeback request; b_ready out 1.
REQ-007 alloc_valid/alloc_wa  in  1/5  issue stage marks a destination as owned by the long-latency unit.
REQ-008 re1/ra1, re2/ra2  in  1/5 each  issue-stage read enables and addresses for hazard check.
REQ-009 we/wa/wd  out  1/5/32  register-file write port, one write per cycle.
REQ-010 pending  out  32  per-register outstanding long-latency write; stall  out  1  read hazard.

Function
REQ-011 Queue SHALL be in-order FIFO of {src, wa, wd}; up to two enqueues (A then B) and one dequeue per cycle.
REQ-012 Same-cycle enqueues SHALL store A's entry ahead of B's.
REQ-013 free = DEPTH - count + (dequeue this cycle ? 1 : 0); a_ready = free>=1; b_ready = a_valid ? free>=2 : free>=1.
REQ-014 Handshake SHALL complete on edge where valid && ready; ready is combinational and SHALL not depend on own valid.
REQ-015 Request with wa==0 SHALL be accepted (ready as above) but not stored; no pending change.
REQ-016 we SHALL equal !empty; wa/wd SHALL equal head entry; head SHALL pop every cycle we=1.
REQ-017 Latency: request accepted at edge N into empty queue SHALL appear on write port during cycle N+1.
REQ-018 Full queue with simultaneous dequeue SHALL accept one new entry (free=1).
REQ-019 Pointers SHALL wrap modulo DEPTH; count width log2(DEPTH)+1; full at count==DEPTH.
REQ-020 pending[r] SHALL set on edge with alloc_valid && alloc_wa==r && r!=0.
REQ-021 pending[r] SHALL clear on edge where head popped with src==B and wa==r.
REQ-022 Simultaneous set and clear of same r SHALL leave pending[r]=1; pending[0] SHALL be constant 0.
REQ-023 stall SHALL be 1 when, for k in {1,2}: rek && rak!=0 && (pending[rak] || any non-head valid entry has wa==rak).
REQ-024 Head entry SHALL not cause stall (register file bypasses the active write).
REQ-025 No cycle SHALL drive we=1 with wa==0.

Reset
REQ-026 On cpu_rst at edge: count=0, pointers=0, pending=0; queued entries discarded.
REQ-027 Outputs during/after reset cycle: we=0, wa=0, wd=0, stall=0, a_ready=b_ready=1 (evaluated with cpu_rst low next cycle).
REQ-028 Reset mid-operation SHALL drop in-flight entries without emitting further writes; handshakes in reset cycle are ignored.

Structure
REQ-029 Bus widths (REG_ADDR_BUS, REG_BUS), WRITE_ENABLE and WBQ_DEPTH default SHALL live in the shared defines file.
REQ-030 FIFO storage/pointers SHALL be one sub-module wbq_fifo (dual push, single pop); scoreboard and hazard logic in top.

Verification
REQ-031 Empty queue, a_valid wa=5 wd=0x12345678 at edge N -> we=1 wa=5 wd=0x12345678 during N+1 only, we=0 at N+2.
REQ-032 A(wa=3,0xA) and B(wa=4,0xB) same edge -> writes wa=3 then wa=4 on consecutive cycles.
REQ-033 DEPTH=4, hold a_valid and b_valid each cycle -> count reaches 4, b_ready=0 while a_valid, no entry lost or reordered.
REQ-034 alloc wa=7, B writes wa=7 later -> pending[7]=1 until head pop of that entry, stall=1 for re1 ra1=7 until then; alloc and pop same edge -> pending[7] stays 1.
REQ-035 Request wa=0 with 0xFFFFFFFF -> accepted, we never asserted, pending unchanged.
REQ-036 Queue holding 3 entries, pending[9]=1, assert cpu_rst one cycle -> we=0, pending=0, queue empty; no stale writes afterward.
